// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain controller.
// Holds the sequencer state encoding and the counter sizing helper.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_FIN
    } state_t;

    function automatic int cnt_width(input int len, input int cap);
        int m;
        m = (len > cap) ? len : cap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/scan_ctrl_shreg.sv
// Parallel-load, serial-in shift register; MSB is the serial output.
// Shifts left with the serial input entering at bit 0.
module scan_ctrl_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-test initiator: load a pattern, capture functionally, unload response.
// SE/SI are decoded purely from registered state and the pattern register.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int   CHAIN_LEN      = 32,
    parameter int   CAPTURE_CYCLES = 1,
    parameter logic FILL           = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP_OUT
);

    localparam int CW = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
    localparam logic [CW-1:0] LEN_TC = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_TC = CW'(CAPTURE_CYCLES - 1);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            pat_load;
    logic            pat_shift;
    logic            resp_shift;
    logic [CHAIN_LEN-1:0] pat_q;

    scan_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_pat (
        .clk   (CLK),
        .rn    (RN),
        .load  (pat_load),
        .shift (pat_shift),
        .d     (PAT_IN),
        .sin   (1'b0),
        .q     (pat_q)
    );

    scan_ctrl_shreg #(.WIDTH(CHAIN_LEN)) u_resp (
        .clk   (CLK),
        .rn    (RN),
        .load  (1'b0),
        .shift (resp_shift),
        .d     ('0),
        .sin   (SO),
        .q     (RESP_OUT)
    );

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pat_load   = 1'b0;
        pat_shift  = 1'b0;
        resp_shift = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    state_n  = ST_SHIFT;
                    cnt_n    = '0;
                    pat_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                pat_shift = 1'b1;
                if (ABORT) begin
                    state_n = ST_IDLE;
                end else if (cnt == LEN_TC) begin
                    state_n = ST_CAPTURE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_CAPTURE: begin
                if (ABORT) begin
                    state_n = ST_IDLE;
                end else if (cnt == CAP_TC) begin
                    state_n = ST_UNLOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_UNLOAD: begin
                // the aborting edge may still sample SO; response is void then
                resp_shift = 1'b1;
                if (ABORT) begin
                    state_n = ST_IDLE;
                end else if (cnt == LEN_TC) begin
                    state_n = ST_FIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign SE   = (state == ST_SHIFT) || (state == ST_UNLOAD);
    assign SI   = (state == ST_SHIFT)  ? pat_q[CHAIN_LEN-1] :
                  (state == ST_UNLOAD) ? FILL : 1'b0;
    assign BUSY = (state == ST_SHIFT) || (state == ST_CAPTURE) ||
                  (state == ST_UNLOAD);
    assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: two controllers (capture 1 and 2) each driving
// an 8-flop behavioural chain whose functional next state is ~Q.
module tb_scan_chain_ctrl;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pat = 8'h00;

    logic       so1, se1, si1, busy1, done1;
    logic [7:0] resp1;
    logic       so2, se2, si2, busy2, done2;
    logic [7:0] resp2;

    logic [7:0] ch1 = 8'h00;
    logic [7:0] ch2 = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1), .FILL(1'b0)) u_dut1 (
        .CLK(clk), .RN(rn), .START(start), .ABORT(abort), .PAT_IN(pat),
        .SO(so1), .SE(se1), .SI(si1), .BUSY(busy1), .DONE(done1),
        .RESP_OUT(resp1)
    );

    scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(2), .FILL(1'b0)) u_dut2 (
        .CLK(clk), .RN(rn), .START(start), .ABORT(abort), .PAT_IN(pat),
        .SO(so2), .SE(se2), .SI(si2), .BUSY(busy2), .DONE(done2),
        .RESP_OUT(resp2)
    );

    always_ff @(posedge clk) begin
        ch1 <= se1 ? {ch1[6:0], si1} : ~ch1;
        ch2 <= se2 ? {ch2[6:0], si2} : ~ch2;
    end
    assign so1 = ch1[7];
    assign so2 = ch2[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rn = 1'b0;
        tick();
        tick();
        checks++;
        if ({se1, si1, busy1, done1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", {se1, si1, busy1, done1});
        end
        checks++;
        if (resp1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_resp got %h want 00", resp1);
        end
        rn = 1'b1;
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", busy1);
        end
    endtask

    task automatic test_a5();
        logic exp_se;
        pat = 8'hA5;
        start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            start = 1'b0;
            exp_se = (e >= 1 && e <= 8) || (e >= 10 && e <= 17);
            checks++;
            if (se1 !== exp_se) begin
                errors++;
                $display("FAIL a5_se cyc %0d got %b want %b", e, se1, exp_se);
            end
            checks++;
            if (done1 !== (e == 18)) begin
                errors++;
                $display("FAIL a5_done cyc %0d got %b want %b", e, done1, e == 18);
            end
            checks++;
            if (busy1 !== (e <= 17)) begin
                errors++;
                $display("FAIL a5_busy cyc %0d got %b want %b", e, busy1, e <= 17);
            end
        end
        checks++;
        if (resp1 !== 8'h5A) begin
            errors++;
            $display("FAIL a5_resp got %h want 5a", resp1);
        end
        checks++;
        if (resp2 !== 8'hA5) begin
            errors++;
            $display("FAIL a5_resp_c2 got %h want a5", resp2);
        end
    endtask

    task automatic test_capture2();
        pat = 8'h0F;
        start = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            tick();
            start = 1'b0;
            checks++;
            if (done2 !== (e == 19)) begin
                errors++;
                $display("FAIL c2_done cyc %0d got %b want %b", e, done2, e == 19);
            end
        end
        checks++;
        if (resp2 !== 8'h0F) begin
            errors++;
            $display("FAIL c2_resp got %h want 0f", resp2);
        end
        checks++;
        if (resp1 !== 8'hF0) begin
            errors++;
            $display("FAIL c2_resp_c1 got %h want f0", resp1);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        pat = 8'h3A;
        start = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            if (e == 5) begin
                start = 1'b1;
                pat = 8'hFF;
            end
            tick();
            start = 1'b0;
            if (done1 === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL b2b_dones got %0d want 1", dones);
        end
        checks++;
        if (resp1 !== 8'hC5) begin
            errors++;
            $display("FAIL b2b_resp got %h want c5", resp1);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        pat = 8'hA5;
        start = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            if (e == 12) abort = 1'b1;
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (done1 === 1'b1) dones++;
            if (e == 12) begin
                checks++;
                if ({se1, busy1} !== 2'b00) begin
                    errors++;
                    $display("FAIL abort_ctl got se,busy=%b want 00", {se1, busy1});
                end
            end
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_dones got %0d want 0", dones);
        end
        dones = 0;
        pat = 8'h3C;
        start = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            start = 1'b0;
            if (done1 === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL abort_next_dones got %0d want 1", dones);
        end
        checks++;
        if (resp1 !== 8'hC3) begin
            errors++;
            $display("FAIL abort_next_resp got %h want c3", resp1);
        end
    endtask

    task automatic test_midreset();
        pat = 8'h55;
        start = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            if (e == 4) rn = 1'b0;
            tick();
            start = 1'b0;
        end
        checks++;
        if ({se1, si1, busy1, done1} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_ctl got %b want 0000", {se1, si1, busy1, done1});
        end
        checks++;
        if (resp1 !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_resp got %h want 00", resp1);
        end
        rn = 1'b1;
        tick();
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle busy got %b want 0", busy1);
        end
        pat = 8'hC3;
        start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            start = 1'b0;
            checks++;
            if (done1 !== (e == 18)) begin
                errors++;
                $display("FAIL rst_after_done cyc %0d got %b want %b", e, done1, e == 18);
            end
        end
        checks++;
        if (resp1 !== 8'h3C) begin
            errors++;
            $display("FAIL rst_after_resp got %h want 3c", resp1);
        end
    endtask

    task automatic test_start_abort();
        pat = 8'hFF;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            checks++;
            if ({se1, busy1, done1, busy2} !== 4'b0000) begin
                errors++;
                $display("FAIL start_abort cyc %0d got %b want 0000", e,
                         {se1, busy1, done1, busy2});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_capture2();
        test_back_to_back();
        test_abort();
        test_midreset();
        test_start_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
